// File: rtl/message_sequencer_pkg.sv
// Shared definitions for the on-screen message sequencer: state encoding,
// glyph geometry of the letter renderer, and message length clamping.
package message_sequencer_pkg;

  localparam int LETTER_WIDTH  = 32;
  localparam int LETTER_HEIGHT = 32;

  typedef enum logic [1:0] {IDLE, REVEAL, BLINK, SHOW} msg_state_t;

  function automatic logic [3:0] clamp_len(input logic [3:0] req, input int max_len);
    return (req > 4'(max_len)) ? 4'(max_len) : req;
  endfunction

endpackage

// File: rtl/message_sequencer_if.sv
// Control, buffer-write and pixel/letter signals between game logic, the
// message sequencer and the letter renderer.
interface message_sequencer_if;

  logic        startOfFrame;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic        wrEn;
  logic [3:0]  wrAddr;
  logic [3:0]  wrData;
  logic        start;
  logic [3:0]  msgLen;
  logic        clear;
  logic        ready;
  logic        busy;
  logic        done;
  logic [3:0]  letter;
  logic [10:0] offsetX;
  logic [10:0] offsetY;
  logic        drawLetter;

  modport master (
    output startOfFrame, pixelX, pixelY, wrEn, wrAddr, wrData, start, msgLen, clear,
    input  ready, busy, done, letter, offsetX, offsetY, drawLetter
  );

  modport slave (
    input  startOfFrame, pixelX, pixelY, wrEn, wrAddr, wrData, start, msgLen, clear,
    output ready, busy, done, letter, offsetX, offsetY, drawLetter
  );

endinterface

// File: rtl/message_sequencer_square.sv
// Combinational hit test of one glyph-sized rectangle; offset is the pixel
// position relative to the rectangle origin (meaningful only when hit=1).
module message_sequencer_square
  import message_sequencer_pkg::*;
#(
  parameter int ORIGIN_X = 0,
  parameter int ORIGIN_Y = 0,
  parameter int WIDTH    = LETTER_WIDTH,
  parameter int HEIGHT   = LETTER_HEIGHT
) (
  input  logic [10:0] pixel_x,
  input  logic [10:0] pixel_y,
  output logic        hit,
  output logic [10:0] off_x,
  output logic [10:0] off_y
);

  localparam logic [10:0] X0 = 11'(ORIGIN_X);
  localparam logic [10:0] X1 = 11'(ORIGIN_X + WIDTH);
  localparam logic [10:0] Y0 = 11'(ORIGIN_Y);
  localparam logic [10:0] Y1 = 11'(ORIGIN_Y + HEIGHT);

  assign hit   = (pixel_x >= X0) && (pixel_x < X1) && (pixel_y >= Y0) && (pixel_y < Y1);
  assign off_x = pixel_x - X0;
  assign off_y = pixel_y - Y0;

endmodule

// File: rtl/message_sequencer.sv
// Typewriter reveal, blink and hold of a buffered letter message; the pixel
// path is registered (one cycle latency) and start is held off via ready.
module message_sequencer
  import message_sequencer_pkg::*;
#(
  parameter int MAX_LETTERS   = 8,
  parameter int TOP_LEFT_X    = 200,
  parameter int TOP_LEFT_Y    = 5,
  parameter int PITCH         = 50,
  parameter int REVEAL_FRAMES = 15,
  parameter int BLINK_FRAMES  = 10,
  parameter int BLINK_TOGGLES = 6
) (
  input logic          clk,
  input logic          resetN,
  message_sequencer_if.slave bus
);

  msg_state_t state, state_n;
  logic [3:0] len, len_n, reveal_cnt, reveal_n, reveal_step;
  logic [7:0] frame_cnt, frame_n, toggle_cnt, toggle_n;
  logic       visible, visible_n, done_n;
  logic       ready_int, accept, wr_ok;
  logic [3:0] code_mem [MAX_LETTERS];

  assign ready_int = (state == IDLE) || (state == SHOW);
  assign accept    = bus.start && ready_int && !bus.clear;
  assign wr_ok     = bus.wrEn && !bus.busy && (bus.wrAddr < 4'(MAX_LETTERS));
  // Gated by reset so every output reads 0 while reset is held.
  assign bus.ready = ready_int && resetN;
  assign bus.busy  = (state == REVEAL) || (state == BLINK);
  assign reveal_step = (reveal_cnt < len) ? reveal_cnt + 4'd1 : reveal_cnt;

  always_comb begin
    state_n   = state;
    len_n     = len;
    reveal_n  = reveal_cnt;
    frame_n   = frame_cnt;
    toggle_n  = toggle_cnt;
    visible_n = visible;
    done_n    = 1'b0;
    if (bus.clear) begin
      state_n   = IDLE;
      len_n     = 4'd0;
      reveal_n  = 4'd0;
      frame_n   = 8'd0;
      toggle_n  = 8'd0;
      visible_n = 1'b0;
    end else if (accept) begin
      len_n     = clamp_len(bus.msgLen, MAX_LETTERS);
      frame_n   = 8'd0;
      toggle_n  = 8'd0;
      visible_n = 1'b0;
      if (clamp_len(bus.msgLen, MAX_LETTERS) == 4'd0) begin
        state_n  = IDLE;
        reveal_n = 4'd0;
        done_n   = 1'b1;
      end else begin
        state_n  = REVEAL;
        reveal_n = 4'd1;
      end
    end else if (bus.startOfFrame) begin
      case (state)
        REVEAL: begin
          if (frame_cnt + 8'd1 == 8'(REVEAL_FRAMES)) begin
            frame_n  = 8'd0;
            reveal_n = reveal_step;
            if (reveal_step == len) begin
              state_n   = BLINK;
              visible_n = 1'b1;
              toggle_n  = 8'd0;
            end
          end else begin
            frame_n = frame_cnt + 8'd1;
          end
        end
        BLINK: begin
          if (frame_cnt + 8'd1 == 8'(BLINK_FRAMES)) begin
            frame_n   = 8'd0;
            toggle_n  = toggle_cnt + 8'd1;
            visible_n = !visible;
            if (toggle_cnt + 8'd1 == 8'(BLINK_TOGGLES)) begin
              state_n   = SHOW;
              visible_n = 1'b1;
              done_n    = 1'b1;
            end
          end else begin
            frame_n = frame_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  logic [MAX_LETTERS-1:0] hit;
  logic [10:0] slot_off_x [MAX_LETTERS];
  logic [10:0] slot_off_y [MAX_LETTERS];

  for (genvar i = 0; i < MAX_LETTERS; i++) begin : g_slot
    message_sequencer_square #(
      .ORIGIN_X(TOP_LEFT_X + i * PITCH),
      .ORIGIN_Y(TOP_LEFT_Y)
    ) u_square (
      .pixel_x(bus.pixelX),
      .pixel_y(bus.pixelY),
      .hit    (hit[i]),
      .off_x  (slot_off_x[i]),
      .off_y  (slot_off_y[i])
    );
  end

  logic [3:0]  vis_lim, sel_code;
  logic [10:0] sel_off_x, sel_off_y;
  logic        sel_hit;

  always_comb begin
    vis_lim = 4'd0;
    case (state)
      REVEAL:  vis_lim = reveal_cnt;
      BLINK:   vis_lim = visible ? len : 4'd0;
      SHOW:    vis_lim = len;
      default: vis_lim = 4'd0;
    endcase
    sel_hit   = 1'b0;
    sel_code  = 4'd0;
    sel_off_x = 11'd0;
    sel_off_y = 11'd0;
    // Walk downwards so the lowest overlapping slot is the last to win.
    for (int i = MAX_LETTERS - 1; i >= 0; i--) begin
      if (hit[i] && (4'(i) < vis_lim)) begin
        sel_hit   = 1'b1;
        sel_code  = code_mem[i];
        sel_off_x = slot_off_x[i];
        sel_off_y = slot_off_y[i];
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state          <= IDLE;
      len            <= 4'd0;
      reveal_cnt     <= 4'd0;
      frame_cnt      <= 8'd0;
      toggle_cnt     <= 8'd0;
      visible        <= 1'b0;
      bus.done       <= 1'b0;
      bus.letter     <= 4'd0;
      bus.offsetX    <= 11'd0;
      bus.offsetY    <= 11'd0;
      bus.drawLetter <= 1'b0;
      for (int i = 0; i < MAX_LETTERS; i++) code_mem[i] <= 4'd0;
    end else begin
      state          <= state_n;
      len            <= len_n;
      reveal_cnt     <= reveal_n;
      frame_cnt      <= frame_n;
      toggle_cnt     <= toggle_n;
      visible        <= visible_n;
      bus.done       <= done_n;
      bus.letter     <= sel_code;
      bus.offsetX    <= sel_off_x;
      bus.offsetY    <= sel_off_y;
      bus.drawLetter <= sel_hit;
      for (int i = 0; i < MAX_LETTERS; i++) begin
        if (wr_ok && (bus.wrAddr == 4'(i))) code_mem[i] <= bus.wrData;
      end
    end
  end

endmodule

// File: tb/tb_message_sequencer.sv
// Directed bench for message_sequencer: reveal timing, blink pattern, pixel
// mapping, length clamping, write blocking, clear priority and async reset.
module tb_message_sequencer;

  logic clk;
  logic resetN;
  int   total;
  int   bad;

  message_sequencer_if bus();

  message_sequencer #(
    .MAX_LETTERS  (8),
    .TOP_LEFT_X   (200),
    .TOP_LEFT_Y   (5),
    .PITCH        (50),
    .REVEAL_FRAMES(2),
    .BLINK_FRAMES (1),
    .BLINK_TOGGLES(4)
  ) dut (
    .clk   (clk),
    .resetN(resetN),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick();
    bus.startOfFrame = 1'b1;
    step(1);
    bus.startOfFrame = 1'b0;
  endtask

  task automatic probe(input int x, input int y);
    bus.pixelX = 11'(x);
    bus.pixelY = 11'(y);
    step(1);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    resetN = 1'b0;
    bus.startOfFrame = 1'b0;
    bus.pixelX = 11'd0;
    bus.pixelY = 11'd0;
    bus.wrEn   = 1'b0;
    bus.wrAddr = 4'd0;
    bus.wrData = 4'd0;
    bus.start  = 1'b0;
    bus.msgLen = 4'd0;
    bus.clear  = 1'b0;
    #2;
    chk("rst_draw",  bus.drawLetter, 0);
    chk("rst_ready", bus.ready, 0);
    chk("rst_busy",  bus.busy, 0);
    chk("rst_done",  bus.done, 0);
    step(2);
    resetN = 1'b1;
    step(1);
    chk("idle_ready", bus.ready, 1);

    for (int i = 0; i < 8; i++) begin
      bus.wrEn   = 1'b1;
      bus.wrAddr = 4'(i);
      bus.wrData = 4'(i + 1);
      step(1);
    end
    bus.wrEn = 1'b0;
    probe(200, 5);
    chk("idle_blank", bus.drawLetter, 0);

    // Three-letter message: slot 1 after 2 ticks, slot 2 and BLINK after 4.
    bus.start = 1'b1; bus.msgLen = 4'd3;
    step(1);
    bus.start = 1'b0;
    chk("rev_busy",  bus.busy, 1);
    chk("rev_ready", bus.ready, 0);
    probe(200, 5);
    chk("rev_s0_draw", bus.drawLetter, 1);
    chk("rev_s0_code", bus.letter, 1);
    probe(250, 5);
    chk("rev_s1_t0", bus.drawLetter, 0);
    tick(); probe(250, 5);
    chk("rev_s1_t1", bus.drawLetter, 0);
    tick(); probe(250, 5);
    chk("rev_s1_t2", bus.drawLetter, 1);
    chk("rev_s1_code", bus.letter, 2);
    probe(300, 5);
    chk("rev_s2_t2", bus.drawLetter, 0);
    tick(); tick(); probe(300, 5);
    chk("rev_s2_t4", bus.drawLetter, 1);
    chk("rev_s2_code", bus.letter, 3);

    probe(200, 5);
    chk("blink_on0", bus.drawLetter, 1);
    tick(); step(1);
    chk("blink_t1", bus.drawLetter, 0);
    tick(); step(1);
    chk("blink_t2", bus.drawLetter, 1);
    tick(); step(1);
    chk("blink_t3", bus.drawLetter, 0);
    tick();
    chk("done_pulse", bus.done, 1);
    chk("show_ready", bus.ready, 1);
    chk("show_busy",  bus.busy, 0);
    step(1);
    chk("done_once", bus.done, 0);
    chk("show_s0",   bus.drawLetter, 1);

    probe(250, 5);
    chk("pix_code", bus.letter, 2);
    chk("pix_offx", bus.offsetX, 0);
    chk("pix_offy", bus.offsetY, 0);
    chk("pix_draw", bus.drawLetter, 1);
    probe(282, 5);
    chk("pix_edge_draw", bus.drawLetter, 0);
    chk("pix_edge_code", bus.letter, 0);
    probe(303, 9);
    chk("pix_s2_code", bus.letter, 3);
    chk("pix_s2_offx", bus.offsetX, 3);
    chk("pix_s2_offy", bus.offsetY, 4);
    probe(350, 5);
    chk("pix_s3_hidden", bus.drawLetter, 0);

    // Clear wins over a simultaneous start.
    bus.start = 1'b1; bus.msgLen = 4'd3; bus.clear = 1'b1;
    step(1);
    bus.start = 1'b0; bus.clear = 1'b0;
    chk("clr_busy",  bus.busy, 0);
    chk("clr_ready", bus.ready, 1);
    probe(200, 5);
    chk("clr_blank", bus.drawLetter, 0);
    chk("clr_still_idle", bus.busy, 0);

    // Over-long request clamps to 8; write during REVEAL is dropped.
    bus.start = 1'b1; bus.msgLen = 4'd12;
    step(1);
    bus.start = 1'b0;
    bus.wrEn = 1'b1; bus.wrAddr = 4'd0; bus.wrData = 4'd9;
    step(1);
    bus.wrEn = 1'b0;
    repeat (12) tick();
    probe(500, 5);
    chk("len8_s6_draw", bus.drawLetter, 1);
    chk("len8_s6_code", bus.letter, 7);
    probe(550, 5);
    chk("len8_s7_early", bus.drawLetter, 0);
    tick(); tick(); probe(550, 5);
    chk("len8_s7_draw", bus.drawLetter, 1);
    chk("len8_s7_code", bus.letter, 8);
    chk("len8_busy", bus.busy, 1);
    repeat (4) tick();
    step(1);
    probe(550, 5);
    chk("len8_show_s7", bus.letter, 8);
    probe(600, 5);
    chk("no_slot8", bus.drawLetter, 0);
    probe(200, 5);
    chk("wr_ignored", bus.letter, 1);

    // Zero-length start pulses done and stays idle.
    bus.start = 1'b1; bus.msgLen = 4'd0;
    step(1);
    bus.start = 1'b0;
    chk("len0_done", bus.done, 1);
    chk("len0_busy", bus.busy, 0);
    step(1);
    chk("len0_done_once", bus.done, 0);
    probe(200, 5);
    chk("len0_idle", bus.drawLetter, 0);

    // Asynchronous reset in BLINK.
    bus.start = 1'b1; bus.msgLen = 4'd2;
    step(1);
    bus.start = 1'b0;
    tick(); tick();
    probe(200, 5);
    chk("pre_rst_draw", bus.drawLetter, 1);
    chk("pre_rst_busy", bus.busy, 1);
    resetN = 1'b0;
    #1;
    chk("arst_draw",  bus.drawLetter, 0);
    chk("arst_code",  bus.letter, 0);
    chk("arst_busy",  bus.busy, 0);
    chk("arst_ready", bus.ready, 0);
    #3;
    resetN = 1'b1;
    step(1);
    chk("post_rst_ready", bus.ready, 1);
    chk("post_rst_busy",  bus.busy, 0);
    bus.start = 1'b1; bus.msgLen = 4'd1;
    step(1);
    bus.start = 1'b0;
    probe(200, 5);
    chk("buf_cleared_draw", bus.drawLetter, 1);
    chk("buf_cleared_code", bus.letter, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
